cdc_req_ack_tx: RTL
===================

Name: cdc_req_ack_tx

Overview:
Source-side controller for a 4-phase req/ack clock-domain crossing of a multi-bit word (e.g. bridge command/data into the core domain).
- Accepts a word on a valid/ready interface and holds it stable on xfer_data.
- Drives xfer_req and sequences the full handshake against an asynchronous ack, which is synchronized internally by 3 flops.
- Recovers from a silent far side via timeout.

Parameters:
WIDTH, 32, width of transferred word
TIMEOUT_CYCLES, 1024, max cycles spent waiting in REQ_HI or REQ_LO before abort; 0 disables timeout

Ports:
clk  input  1  single clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  word offered
in_ready  output  1  block can accept word this cycle
in_data  input  WIDTH  word to transfer
xfer_req  output  1  4-phase request to far domain (registered)
xfer_data  output  WIDTH  held word (registered, stable while xfer_req or wait states active)
xfer_ack_async  input  1  far-domain ack, asynchronous to clk
busy  output  1  state != IDLE
done  output  1  one-cycle pulse: handshake completed normally
timeout_err  output  1  one-cycle pulse: handshake aborted by timeout

Behaviour:
- Ack sync: 3 flops s1->s2->s3 on xfer_ack_async; ack_s = s3; all cleared by reset. Latency ack_async->ack_s = 3 edges.
- Reset (any cycle, incl. mid-handshake): state=IDLE, xfer_req=0, xfer_data=0, done=0, timeout_err=0, counter=0, sync flops=0.
- in_ready = (state==IDLE) && !ack_s. Combinational from registers only. Never depends on in_valid.
- States:
  - IDLE: on in_valid&&in_ready: latch in_data into xfer_data, xfer_req<=1, -> REQ_HI.
  - REQ_HI: ack_s==1 -> xfer_req<=0, -> REQ_LO. Else if timeout -> xfer_req<=0, -> ABORT.
  - REQ_LO: ack_s==0 -> done<=1, -> IDLE. Else if timeout -> ABORT.
  - ABORT: xfer_req=0. Wait for ack_s==0 with no timeout, then timeout_err<=1, -> IDLE.
- Timeout counter:
  - Cleared on every state entry.
  - Increments each cycle in REQ_HI/REQ_LO.
  - Timeout fires when count == TIMEOUT_CYCLES-1.
  - Width = $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Simultaneous ack_s transition and timeout in the same cycle: ack wins, no abort.
- in_valid while busy: ignored, no data latched. xfer_data changes only on acceptance.
- Far side holding ack high after reset: in_ready stays 0 until ack_s==0. No spurious handshake.
- done and timeout_err are mutually exclusive and high for exactly one cycle.
- Zero-delay loopback timing (ack_async = xfer_req):
  - Accept at edge E0.
  - xfer_req high after E0.
  - ack_s high after E3.
  - xfer_req low after E4.
  - ack_s low after E7.
  - done high and in_ready high after E8.
  - Throughput is one word per 9 cycles.

Decomposition:
- Package cdc_hs_pkg:
  - typedef enum logic [1:0] hs_state_e {HS_IDLE, HS_REQ_HI, HS_REQ_LO, HS_ABORT}
  - localparam HS_SYNC_STAGES = 3
- Sub-module hs_timeout_ctr:
  - Parameter TIMEOUT_CYCLES.
  - Ports clk, reset, clear, enable, expired.
  - Ties expired=0 when TIMEOUT_CYCLES==0.
- FSM, data hold register and ack sync stay in the top module.

Test Plan:
- Zero-delay loopback, in_data=32'hDEADBEEF at E0:
  - xfer_req rises after E0 and falls after E4.
  - xfer_data==32'hDEADBEEF throughout.
  - done pulses after E8.
  - in_ready low for cycles after E0..E7.
- Back-to-back: in_valid held high with words 1,2,3:
  - Three handshakes.
  - Accepts spaced exactly 9 cycles apart.
  - xfer_data sequence 1,2,3.
  - Three done pulses, no timeout_err.
- TIMEOUT_CYCLES=16, ack tied 0:
  - xfer_req drops after 16 cycles in REQ_HI.
  - ABORT completes immediately.
  - timeout_err pulses once, done never.
  - in_ready returns high.
- TIMEOUT_CYCLES=16, ack raised then stuck high:
  - Timeout in REQ_LO, then stays in ABORT while ack high.
  - Release ack: timeout_err 4 cycles later.
  - in_ready high only after ack_s==0.
- Reset asserted 2 cycles after acceptance:
  - Next edge gives xfer_req=0, busy=0, xfer_data=0.
  - With ack released, in_ready=1 once ack_s==0.
  - No done or timeout_err pulse.
- Randomized far-side ack delays 0..40 cycles with TIMEOUT_CYCLES=1024:
  - Every accepted word yields exactly one done.
  - xfer_data never changes while busy.

Source files
------------

// File: rtl/cdc_hs_pkg.sv
// -----------------------------------------------------------------------------
// cdc_hs_pkg
// Shared types and constants for the 4-phase req/ack source-side controller.
//   hs_state_e      : handshake FSM states
//   HS_SYNC_STAGES  : depth of the ack synchronizer
//   hs_ctr_width()  : width of the timeout counter for a given cycle budget
// -----------------------------------------------------------------------------
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ_HI,
    HS_REQ_LO,
    HS_ABORT
  } hs_state_e;

  localparam int HS_SYNC_STAGES = 3;

  // Counter must hold values 0..cycles; a disabled timeout (0) still gets
  // one bit so the counter never collapses to zero width.
  function automatic int hs_ctr_width(input int cycles);
    return (cycles <= 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/hs_timeout_ctr.sv
// -----------------------------------------------------------------------------
// hs_timeout_ctr
// Per-state wait counter for the handshake FSM.
//   clk     : clock
//   reset   : synchronous active-high reset
//   clear   : return count to 0 (takes priority over enable)
//   enable  : count this cycle
//   expired : high while enabled and count has reached TIMEOUT_CYCLES-1;
//             constant 0 when TIMEOUT_CYCLES == 0
// -----------------------------------------------------------------------------
module hs_timeout_ctr
  import cdc_hs_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = hs_ctr_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
      // The FSM leaves the waiting state on expiry, so the count never needs
      // to saturate.
      assign expired = enable && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/cdc_req_ack_tx.sv
// -----------------------------------------------------------------------------
// cdc_req_ack_tx
// Source side of a 4-phase req/ack clock-domain crossing for one WIDTH-bit word.
//   clk, reset     : clock, synchronous active-high reset
//   in_valid/ready : word offer / acceptance (ready only in IDLE with ack low)
//   in_data        : word to transfer
//   xfer_req       : registered 4-phase request to the far domain
//   xfer_data      : registered word, held from acceptance until next accept
//   xfer_ack_async : far-domain ack, synchronized here through 3 flops
//   busy           : handshake in progress (state != IDLE)
//   done           : one-cycle pulse on normal completion
//   timeout_err    : one-cycle pulse on abort after a timeout
// -----------------------------------------------------------------------------
module cdc_req_ack_tx
  import cdc_hs_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             xfer_req,
  output logic [WIDTH-1:0] xfer_data,
  input  logic             xfer_ack_async,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  hs_state_e                 state_q, state_d;
  logic                      req_q, req_d;
  logic [WIDTH-1:0]          data_q, data_d;
  logic                      done_q, done_d;
  logic                      terr_q, terr_d;
  logic [HS_SYNC_STAGES-1:0] ack_sync_q;
  logic                      ack_s;
  logic                      ctr_clear;
  logic                      ctr_enable;
  logic                      expired;

  // Ack synchronizer: bit 0 is the first stage, the MSB is the usable ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[HS_SYNC_STAGES-2:0], xfer_ack_async};
    end
  end

  assign ack_s = ack_sync_q[HS_SYNC_STAGES-1];

  // A far side still holding ack from a previous handshake must release it
  // before a new word is taken, otherwise the next REQ_HI would complete
  // against a stale ack.
  assign in_ready = (state_q == HS_IDLE) && !ack_s;

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    terr_d  = 1'b0;
    unique case (state_q)
      HS_IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = HS_REQ_HI;
        end
      end
      HS_REQ_HI: begin
        // Ack is checked first: an ack arriving on the expiry cycle wins.
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = HS_REQ_LO;
        end else if (expired) begin
          req_d   = 1'b0;
          state_d = HS_ABORT;
        end
      end
      HS_REQ_LO: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = HS_IDLE;
        end else if (expired) begin
          state_d = HS_ABORT;
        end
      end
      HS_ABORT: begin
        // Wait (unbounded) for the far side to drop ack so the next
        // handshake starts from a clean return-to-zero.
        req_d = 1'b0;
        if (!ack_s) begin
          terr_d  = 1'b1;
          state_d = HS_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = HS_IDLE;
      end
    endcase
  end

  // The counter restarts on every state entry and runs only while waiting
  // for an ack edge.
  assign ctr_clear  = (state_d != state_q);
  assign ctr_enable = (state_q == HS_REQ_HI) || (state_q == HS_REQ_LO);

  hs_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .expired (expired)
  );

  // NOTE: the data hold register is reset as well, so xfer_data is a known 0
  // after reset rather than whatever was last in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HS_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  assign xfer_req    = req_q;
  assign xfer_data   = data_q;
  assign busy        = (state_q != HS_IDLE);
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule
